barrel_right_pipe: RTL
======================

# barrel_right_pipe

Pipelined 16-bit right shifter for the ALU, the right-direction counterpart of the left barrel shifter. It performs logical, arithmetic or rotate right shifts by 0–15 positions, with one pipeline stage per shift-amount bit. Operands move through a valid/ready handshake, so the ALU result path can apply back-pressure without losing operands. The unit also returns the last bit shifted out, for the status flags.

## Interface
- WIDTH, 16, data width; power of two, 4..32; stage count N = log2(WIDTH)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand present
- in_ready  out  1  unit accepts operand this cycle
- in_data  in  WIDTH  operand
- shft  in  N  shift amount
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (acts as logical)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result
- out_carry  out  1  last bit shifted out

## Operation
- Stage k (k = 0..N-1, in ascending order) shifts right by 2^k when its copy of shft[k] is 1, and passes data through otherwise. Each stage register holds: valid, data, the remaining shft bits, mode, carry.
- Fill bits for the vacated top positions:
  - logical: 0.
  - arithmetic: the operand's original bit WIDTH-1, carried along with the stage.
  - rotate: the bits shifted out at the bottom.
- Carry:
  - Enters stage 0 as 0.
  - A stage that shifts sets carry = its input data[2^k-1]; a stage that does not shift passes carry through unchanged.
  - Net result: out_carry = in_data[shft-1], or 0 when shft = 0. This holds for all three modes; for rotate it equals out_data[WIDTH-1].
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - Stage k advances when stage k is empty or stage k+1 advances; the last stage advances on out_ready.
  - in_ready = !valid_0 || advance_0 (combinational, bubble-collapsing).
  - in_ready is forced to 0 while rst is high.
- out_valid, out_data and out_carry are the last stage's register and stay stable while out_valid && !out_ready.
- The unit preserves order; it never drops or duplicates an operand.

## Timing
- Reset values: every stage valid = 0, data = 0, carry = 0. Outputs: out_valid 0, out_data 0, out_carry 0. in_ready is 0 during rst and 1 on the first cycle after rst deasserts.
- Latency: an operand accepted in cycle t gives out_valid in cycle t+N (t+4 at WIDTH = 16) when the pipeline has no stall.
- Throughput: 1 operand per cycle while out_ready = 1.
- Full pipeline: holds N operands. With out_ready = 0 for the whole period, in_ready falls to 0 once all N stages are valid. Input is accepted on the same cycle a result drains (simultaneous accept and drain).
- Reset during operation: every operand in flight is discarded; out_valid is 0 in the cycle after rst is sampled high.
- shft = 0: the operand passes through unmodified with carry 0, with the same latency.

## Configuration
- BARREL_RIGHT_ROTATE_EN defined: mode 10 rotates as described above.
- Undefined: the rotate fill logic is removed and mode 10 behaves exactly like logical (mode 00), including the carry.
- Latency and handshake are identical either way.

## Structure
- Shared ALU package holds:
  - mode encodings: SHR_LOGICAL = 2'b00, SHR_ARITH = 2'b01, SHR_ROTATE = 2'b10
  - default data width constant, 16
  - shift-amount width, log2(WIDTH)
- One sub-module, barrel_right_stage:
  - parameters: WIDTH, and DIST (its shift distance 2^k)
  - contents: one shift stage with its register and the valid/ready logic
  - top level instantiates N of them in a generate loop.

## Test plan
- Logical: in_data 0xF0F0, shft 4, mode 00 -> out_data 0x0F0F, out_carry 0, out_valid exactly 4 cycles after acceptance.
- Arithmetic: in_data 0x8004, shft 3, mode 01 -> out_data 0xF000, out_carry 1.
- Rotate (macro defined): in_data 0x1234, shft 8, mode 10 -> 0x3412, carry 0. Same input with the macro undefined -> 0x0012, carry 0.
- Zero shift: in_data 0xABCD, shft 0, mode 01 -> 0xABCD, carry 0. Also mode 11 with in_data 0x8000, shft 15 -> 0x0001, carry 0.
- Back-pressure: 6 back-to-back operands with out_ready held low for 5 cycles starting at the first out_valid:
  - in_ready falls with 4 operands held
  - out_data stays stable while stalled
  - all 6 results emerge in order, each matching the reference model
  - no duplicates.
- Reset during operation: 3 operands in flight, rst high for 1 cycle -> out_valid 0 in the next cycle, none of the 3 ever emerges, and a new operand afterwards returns after 4 cycles.

Source files
------------

// File: rtl/barrel_right_pipe_pkg.sv
// Shared ALU definitions for the right barrel shifter: mode encodings and widths.
package barrel_right_pipe_pkg;
  typedef enum logic [1:0] {
    SHR_LOGICAL = 2'b00,
    SHR_ARITH   = 2'b01,
    SHR_ROTATE  = 2'b10
  } shr_mode_e;

  localparam int DEF_WIDTH = 16;
  localparam int SHFT_W    = $clog2(DEF_WIDTH);
endpackage

// File: rtl/barrel_right_stage.sv
// One right-shift stage (distance DIST) with its register and valid/ready slot.
// Rotate fill is present only when BARREL_RIGHT_ROTATE_EN is defined.
module barrel_right_stage
  import barrel_right_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIST  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up_valid,
  output logic                       up_ready,
  input  logic [WIDTH-1:0]           up_data,
  input  logic [$clog2(WIDTH)-1:0]   up_shft,
  input  logic [1:0]                 up_mode,
  input  logic                       up_carry,
  input  logic                       up_sign,
  output logic                       dn_valid,
  input  logic                       dn_ready,
  output logic [WIDTH-1:0]           dn_data,
  output logic [$clog2(WIDTH)-1:0]   dn_shft,
  output logic [1:0]                 dn_mode,
  output logic                       dn_carry,
  output logic                       dn_sign
);
  localparam int BIT = $clog2(DIST);

  logic [DIST-1:0]  fill;
  logic [WIDTH-1:0] nxt_data;
  logic             nxt_carry;

  always_comb begin
    fill = '0;
    case (up_mode)
      SHR_ARITH:  fill = {DIST{up_sign}};
`ifdef BARREL_RIGHT_ROTATE_EN
      SHR_ROTATE: fill = up_data[DIST-1:0];
`endif
      default:    fill = '0;
    endcase
    nxt_data  = up_data;
    nxt_carry = up_carry;
    if (up_shft[BIT]) begin
      nxt_data  = {fill, up_data[WIDTH-1:DIST]};
      nxt_carry = up_data[DIST-1];
    end
  end

`ifndef BARREL_RIGHT_ROTATE_EN
  logic unused_low;
  assign unused_low = ^up_data[DIST-1:0];
`endif

  // Slot accepts when empty or when its occupant moves on this cycle.
  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_shft  <= '0;
      dn_mode  <= '0;
      dn_carry <= 1'b0;
      dn_sign  <= 1'b0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data  <= nxt_data;
        dn_shft  <= up_shft;
        dn_mode  <= up_mode;
        dn_carry <= nxt_carry;
        dn_sign  <= up_sign;
      end
    end
  end
endmodule

// File: rtl/barrel_right_pipe.sv
// Pipelined right barrel shifter, one stage per shift-amount bit, valid/ready in and out.
// BARREL_RIGHT_ROTATE_EN enables rotate mode; otherwise rotate acts as logical.
module barrel_right_pipe
  import barrel_right_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] shft,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_carry
);
  localparam int N = $clog2(WIDTH);

  logic [N:0]                vld_pipe;
  logic [N:0]                rdy;
  logic [N:0][WIDTH-1:0]     data_p;
  logic [N:0][N-1:0]         shft_p;
  logic [N:0][1:0]           mode_p;
  logic [N:0]                carry_p;
  logic [N:0]                sign_p;

  // Index 0 is the input port; index k+1 is the register of stage k.
  assign vld_pipe[0] = in_valid;
  assign data_p[0]   = in_data;
  assign shft_p[0]   = shft;
  assign mode_p[0]   = mode;
  assign carry_p[0]  = 1'b0;
  assign sign_p[0]   = in_data[WIDTH-1];
  assign rdy[N]      = out_ready;

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_stage
      barrel_right_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << k)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .up_valid (vld_pipe[k]),
        .up_ready (rdy[k]),
        .up_data  (data_p[k]),
        .up_shft  (shft_p[k]),
        .up_mode  (mode_p[k]),
        .up_carry (carry_p[k]),
        .up_sign  (sign_p[k]),
        .dn_valid (vld_pipe[k+1]),
        .dn_ready (rdy[k+1]),
        .dn_data  (data_p[k+1]),
        .dn_shft  (shft_p[k+1]),
        .dn_mode  (mode_p[k+1]),
        .dn_carry (carry_p[k+1]),
        .dn_sign  (sign_p[k+1])
      );
    end
  endgenerate

  assign in_ready  = rdy[0] && !rst;
  assign out_valid = vld_pipe[N];
  assign out_data  = data_p[N];
  assign out_carry = carry_p[N];

  logic unused_tail;
  assign unused_tail = ^{shft_p[N], mode_p[N], sign_p[N]};
endmodule
